// File: rtl/multi_alarm_clock.sv
// rtl/multi_alarm_clock.sv - BCD 24-hour clock with NUM_ALARMS slots and a ring/snooze sequencer
//
// Ports:
//   clk, rst_bar           system clock, synchronous active-low reset
//   h1_in..m0_in           BCD hh:mm used by load_time, load_alarm and reset
//   load_time, load_alarm  load clock (seconds cleared) / load slot alarm_sel
//   alarm_sel, alarm_en    slot index for load_alarm / live per-slot enables
//   stop_alarm, snooze     cancel sequence / silence until the next ring period
//   alarm, alarm_src       ring output / slot that started the current sequence
//   tick_1hz               one-cycle pulse per second
//   h1_out..s0_out         current time in BCD
module multi_alarm_clock #(
    parameter int CLK_HZ      = 100,
    parameter int NUM_ALARMS  = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 540,
    parameter int MAX_RINGS   = 3,
    localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_bar,
    input  logic [1:0]            h1_in,
    input  logic [3:0]            h0_in,
    input  logic [2:0]            m1_in,
    input  logic [3:0]            m0_in,
    input  logic                  load_time,
    input  logic                  load_alarm,
    input  logic [SW-1:0]         alarm_sel,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  stop_alarm,
    input  logic                  snooze,
    output logic                  alarm,
    output logic [SW-1:0]         alarm_src,
    output logic                  tick_1hz,
    output logic [1:0]            h1_out,
    output logic [3:0]            h0_out,
    output logic [2:0]            m1_out,
    output logic [3:0]            m0_out,
    output logic [2:0]            s1_out,
    output logic [3:0]            s0_out
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam int WW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
    localparam int NW = $clog2(MAX_RINGS + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SNOOZE_SECS - 1);
    localparam logic [NW-1:0] RINGS_MAX = NW'(MAX_RINGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RING,
        ST_SNOOZE
    } state_t;

    state_t          state;
    logic [PW-1:0]   pre_cnt;
    logic [RW-1:0]   ring_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [NW-1:0]   rings;
    logic            match_pend;
    logic [12:0]     slot_hm [NUM_ALARMS];

    logic [12:0]     in_hm;
    logic [12:0]     now_hm;
    logic            in_valid;
    logic            time_load;
    logic            alarm_load;
    logic            tick_ev;
    logic            any_match;
    logic [SW-1:0]   winner;

    assign in_hm  = {h1_in, h0_in, m1_in, m0_in};
    assign now_hm = {h1_out, h0_out, m1_out, m0_out};

    assign in_valid = (h1_in <= 2'd2) && (h0_in <= 4'd9) &&
                      !((h1_in == 2'd2) && (h0_in > 4'd3)) &&
                      (m1_in <= 3'd5) && (m0_in <= 4'd9);

    assign time_load  = load_time && in_valid;
    // load_time wins even when its own value is rejected
    assign alarm_load = load_alarm && !load_time && in_valid &&
                        ({1'b0, alarm_sel} < (SW + 1)'(NUM_ALARMS));
    // a valid time load swallows a coincident tick everywhere
    assign tick_ev    = tick_1hz && !time_load;

    // Downward scan so the lowest matching index is the one left standing
    always_comb begin
        any_match = 1'b0;
        winner    = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_en[i] && (slot_hm[i] == now_hm) &&
                (s1_out == 3'd0) && (s0_out == 4'd0)) begin
                any_match = 1'b1;
                winner    = SW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_bar) begin
            pre_cnt    <= '0;
            tick_1hz   <= 1'b0;
            match_pend <= 1'b0;
            h1_out     <= h1_in;
            h0_out     <= h0_in;
            m1_out     <= m1_in;
            m0_out     <= m0_in;
            s1_out     <= '0;
            s0_out     <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_hm[i] <= '0;
            end
            state      <= ST_IDLE;
            alarm      <= 1'b0;
            alarm_src  <= '0;
            ring_cnt   <= '0;
            wait_cnt   <= '0;
            rings      <= '0;
        end else begin
            // Prescaler and timekeeping
            if (time_load) begin
                pre_cnt    <= '0;
                tick_1hz   <= 1'b0;
                match_pend <= 1'b0;
                h1_out     <= h1_in;
                h0_out     <= h0_in;
                m1_out     <= m1_in;
                m0_out     <= m0_in;
                s1_out     <= '0;
                s0_out     <= '0;
            end else begin
                if (pre_cnt == PRE_LAST) begin
                    pre_cnt  <= '0;
                    tick_1hz <= 1'b1;
                end else begin
                    pre_cnt  <= pre_cnt + PW'(1);
                    tick_1hz <= 1'b0;
                end
                // match is judged on the time that this tick produces
                match_pend <= tick_1hz;
                if (tick_1hz) begin
                    if (s0_out == 4'd9) begin
                        s0_out <= '0;
                        if (s1_out == 3'd5) begin
                            s1_out <= '0;
                            if (m0_out == 4'd9) begin
                                m0_out <= '0;
                                if (m1_out == 3'd5) begin
                                    m1_out <= '0;
                                    if ((h1_out == 2'd2) && (h0_out == 4'd3)) begin
                                        h1_out <= '0;
                                        h0_out <= '0;
                                    end else if (h0_out == 4'd9) begin
                                        h0_out <= '0;
                                        h1_out <= h1_out + 2'd1;
                                    end else begin
                                        h0_out <= h0_out + 4'd1;
                                    end
                                end else begin
                                    m1_out <= m1_out + 3'd1;
                                end
                            end else begin
                                m0_out <= m0_out + 4'd1;
                            end
                        end else begin
                            s1_out <= s1_out + 3'd1;
                        end
                    end else begin
                        s0_out <= s0_out + 4'd1;
                    end
                end
            end

            if (alarm_load) begin
                slot_hm[alarm_sel] <= in_hm;
            end

            // Ring / snooze sequencer; alarm is registered with the state
            case (state)
                ST_IDLE: begin
                    alarm <= 1'b0;
                    if (match_pend && any_match && !time_load) begin
                        state     <= ST_RING;
                        alarm     <= 1'b1;
                        alarm_src <= winner;
                        ring_cnt  <= '0;
                        rings     <= NW'(1);
                    end
                end
                ST_RING: begin
                    if (stop_alarm) begin
                        state <= ST_IDLE;
                        alarm <= 1'b0;
                    end else if (snooze || (tick_ev && (ring_cnt == RING_LAST))) begin
                        state    <= (rings < RINGS_MAX) ? ST_SNOOZE : ST_IDLE;
                        alarm    <= 1'b0;
                        wait_cnt <= '0;
                    end else if (tick_ev) begin
                        ring_cnt <= ring_cnt + RW'(1);
                    end
                end
                ST_SNOOZE: begin
                    if (stop_alarm) begin
                        state <= ST_IDLE;
                        alarm <= 1'b0;
                    end else if (tick_ev) begin
                        if (wait_cnt == WAIT_LAST) begin
                            state    <= ST_RING;
                            alarm    <= 1'b1;
                            rings    <= rings + NW'(1);
                            ring_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + WW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    alarm <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb/tb_multi_alarm_clock.sv - directed self-checking bench for multi_alarm_clock
module tb_multi_alarm_clock;

    logic       clk = 1'b0;
    logic       rst_bar = 1'b0;
    logic [1:0] h1_in = '0;
    logic [3:0] h0_in = '0;
    logic [2:0] m1_in = '0;
    logic [3:0] m0_in = '0;
    logic       load_time = 1'b0;
    logic       load_alarm = 1'b0;
    logic [1:0] alarm_sel = '0;
    logic [3:0] alarm_en = '0;
    logic       stop_alarm = 1'b0;
    logic       snooze = 1'b0;
    logic       alarm;
    logic [1:0] alarm_src;
    logic       tick_1hz;
    logic [1:0] h1_out;
    logic [3:0] h0_out;
    logic [2:0] m1_out;
    logic [3:0] m0_out;
    logic [2:0] s1_out;
    logic [3:0] s0_out;

    int passed = 0;
    int total  = 0;
    int n;

    multi_alarm_clock #(
        .CLK_HZ(4), .NUM_ALARMS(4), .RING_SECS(3), .SNOOZE_SECS(2), .MAX_RINGS(2)
    ) dut (
        .clk(clk), .rst_bar(rst_bar),
        .h1_in(h1_in), .h0_in(h0_in), .m1_in(m1_in), .m0_in(m0_in),
        .load_time(load_time), .load_alarm(load_alarm),
        .alarm_sel(alarm_sel), .alarm_en(alarm_en),
        .stop_alarm(stop_alarm), .snooze(snooze),
        .alarm(alarm), .alarm_src(alarm_src), .tick_1hz(tick_1hz),
        .h1_out(h1_out), .h0_out(h0_out), .m1_out(m1_out),
        .m0_out(m0_out), .s1_out(s1_out), .s0_out(s0_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // nibble-aligned hhmmss so expected values read as hex literals
    function automatic logic [31:0] now_t();
        return {8'h00, 2'b00, h1_out, h0_out, 1'b0, m1_out, m0_out, 1'b0, s1_out, s0_out};
    endfunction

    task automatic set_in(input logic [1:0] a, input logic [3:0] b,
                          input logic [2:0] c, input logic [3:0] d);
        h1_in = a; h0_in = b; m1_in = c; m0_in = d;
    endtask

    task automatic do_load_time(input logic [1:0] a, input logic [3:0] b,
                                input logic [2:0] c, input logic [3:0] d);
        set_in(a, b, c, d);
        load_time = 1'b1;
        step();
        load_time = 1'b0;
    endtask

    task automatic do_load_alarm(input logic [1:0] sel, input logic [1:0] a, input logic [3:0] b,
                                 input logic [2:0] c, input logic [3:0] d);
        set_in(a, b, c, d);
        alarm_sel  = sel;
        load_alarm = 1'b1;
        step();
        load_alarm = 1'b0;
    endtask

    // leaves the bench sampling the cycle in which tick_1hz is high
    task automatic wait_tick();
        int k = 0;
        do begin
            step();
            k++;
        end while (tick_1hz !== 1'b1 && k < 8);
        if (tick_1hz !== 1'b1) chk("tick_timeout", tick_1hz, 1);
    endtask

    task automatic wait_ticks(input int cnt);
        for (int i = 0; i < cnt; i++) wait_tick();
    endtask

    task automatic run_len(input logic lvl, output int len);
        len = 0;
        while (alarm === lvl && len < 100) begin
            len++;
            step();
        end
    endtask

    task automatic quiet(input int cyc, input string tag);
        int hi = 0;
        for (int i = 0; i < cyc; i++) begin
            step();
            if (alarm !== 1'b0) hi++;
        end
        chk(tag, hi, 0);
    endtask

    initial begin
        // 1: reset load, tick period, day rollover
        set_in(2, 3, 5, 9);
        step();
        rst_bar = 1'b1;
        chk("rst_time", now_t(), 32'h235900);
        chk("rst_tick", tick_1hz, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_src", alarm_src, 0);
        wait_tick();
        n = 0;
        do begin
            step();
            n++;
        end while (tick_1hz !== 1'b1 && n < 10);
        chk("tick_period", n, 4);
        chk("time_1s", now_t(), 32'h235901);
        wait_ticks(58);
        chk("time_235959", now_t(), 32'h235959);
        step();
        chk("rollover", now_t(), 32'h000000);

        // 2: valid load, rejected load leaves time and prescaler alone
        do_load_time(1, 4, 0, 7);
        chk("load_time", now_t(), 32'h140700);
        chk("load_tick_clr", tick_1hz, 0);
        set_in(2, 4, 0, 0);
        load_time = 1'b1;
        step();
        load_time = 1'b0;
        chk("bad_load_time", now_t(), 32'h140700);
        step();
        step();
        chk("bad_load_pre_a", tick_1hz, 0);
        step();
        chk("bad_load_pre_b", tick_1hz, 1);
        step();
        chk("time_after_bad", now_t(), 32'h140701);

        // 2b: load_time with load_alarm drops the slot write
        set_in(1, 0, 3, 0);
        alarm_sel  = 2'd1;
        load_time  = 1'b1;
        load_alarm = 1'b1;
        step();
        load_time  = 1'b0;
        load_alarm = 1'b0;
        chk("dual_load_time", now_t(), 32'h103000);
        alarm_en = 4'b0010;
        do_load_time(1, 0, 2, 9);
        wait_ticks(60);
        step();
        chk("dual_time_1030", now_t(), 32'h103000);
        step();
        chk("dual_no_slot", alarm, 0);
        alarm_en = 4'b0000;

        // 3: two matching slots, lowest index wins
        do_load_alarm(1, 1, 4, 0, 8);
        do_load_alarm(2, 1, 4, 0, 8);
        do_load_time(1, 4, 0, 7);
        alarm_en = 4'b0110;
        wait_ticks(60);
        chk("time_140759", now_t(), 32'h140759);
        step();
        chk("time_140800", now_t(), 32'h140800);
        chk("match_cycle", alarm, 0);
        step();
        chk("alarm_rise", alarm, 1);
        chk("alarm_src", alarm_src, 1);

        // 4: free-running sequence ring/snooze/ring/idle
        run_len(1'b1, n);
        chk("ring1_len", n, 11);
        run_len(1'b0, n);
        chk("snooze_len", n, 8);
        chk("src_hold", alarm_src, 1);
        run_len(1'b1, n);
        chk("ring2_len", n, 12);
        quiet(40, "after_max_rings");

        // 5: snooze in first ring, snooze in last ring ends sequence
        do_load_alarm(3, 1, 4, 1, 0);
        alarm_en = 4'b1000;
        do_load_time(1, 4, 0, 9);
        wait_ticks(60);
        step();
        step();
        chk("rise_slot3", alarm, 1);
        chk("src_slot3", alarm_src, 3);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("snooze_fall", alarm, 0);
        run_len(1'b0, n);
        chk("snooze_gap", n, 6);
        chk("resume_ring", alarm, 1);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        quiet(40, "snooze_last_ring");

        // 5b: stop during SNOOZE
        do_load_time(1, 4, 0, 9);
        wait_ticks(60);
        step();
        step();
        chk("rise_again", alarm, 1);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("snooze_again", alarm, 0);
        stop_alarm = 1'b1;
        step();
        stop_alarm = 1'b0;
        quiet(40, "stop_in_snooze");

        // 6: reset during RING
        do_load_time(1, 4, 0, 9);
        wait_ticks(60);
        step();
        step();
        chk("rise_pre_rst", alarm, 1);
        set_in(1, 2, 3, 4);
        rst_bar = 1'b0;
        step();
        rst_bar = 1'b1;
        chk("rst_ring_alarm", alarm, 0);
        chk("rst_ring_time", now_t(), 32'h123400);
        chk("rst_ring_src", alarm_src, 0);
        do_load_time(1, 4, 0, 9);
        wait_ticks(60);
        step();
        chk("rst_time_1410", now_t(), 32'h141000);
        step();
        chk("rst_slots_clr", alarm, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
Parametrised successor to the team's single-alarm clock. Keeps a BCD 24-hour hh:mm:ss time from the system clock using a 1 Hz tick enable, with no derived clock. Holds NUM_ALARMS independently loadable and enabled alarm slots. Drives one alarm output through a ring/snooze state machine with programmable ring length, snooze interval and ring count.

Parameters:
CLK_HZ, 100, system clock frequency; the prescaler divides by this to make the 1 Hz tick
NUM_ALARMS, 4, number of alarm slots (must be >= 2)
RING_SECS, 60, length of one ring period, in ticks
SNOOZE_SECS, 540, silent gap between ring periods, in ticks
MAX_RINGS, 3, total ring periods per trigger, including the first

Ports:
clk  in  1  system clock
rst_bar  in  1  reset; one clock, reset is synchronous and active-low
h1_in  in  2  hours tens (0-2)
h0_in  in  4  hours units (0-9)
m1_in  in  3  minutes tens (0-5)
m0_in  in  4  minutes units (0-9)
load_time  in  1  load clock hh:mm from inputs; seconds cleared
load_alarm  in  1  load slot alarm_sel with hh:mm from inputs
alarm_sel  in  SW=max(1,$clog2(NUM_ALARMS))  slot index for load_alarm
alarm_en  in  NUM_ALARMS  per-slot enable, sampled live
stop_alarm  in  1  cancel ringing/snoozing
snooze  in  1  silence now, ring again after SNOOZE_SECS
alarm  out  1  high while ringing
alarm_src  out  SW  index of the slot that triggered the current sequence
tick_1hz  out  1  one-cycle pulse per second
h1_out, h0_out, m1_out, m0_out, s1_out, s0_out  out  2/4/3/4/3/4  current time (BCD)

Behaviour:
- Reset (rst_bar low at posedge clk): time = h1_in:h0_in:m1_in:m0_in:00; all slots = 00:00; prescaler = 0; FSM = IDLE; alarm = 0; alarm_src = 0; tick_1hz = 0; counters = 0. Reset in the middle of any sequence aborts it.
- Prescaler: counts 0..CLK_HZ-1. tick_1hz is registered and is high for the cycle after the count reaches CLK_HZ-1. The count wraps to 0.
- Time advances on tick_1hz. BCD carries: s 59->00 increments minutes; m 59->00 increments hours; 09->10, 19->20, 23:59:59->00:00:00.
- load_time: validated (h1<=2, h0<=9, h1==2 implies h0<=3, m1<=5, m0<=9). If invalid, the load is ignored entirely. If valid, the next cycle shows time = inputs:00, the prescaler clears, and any same-cycle tick is discarded.
- load_alarm: same validation. Writes slot alarm_sel. alarm_sel >= NUM_ALARMS is ignored.
- Priority: load_time over load_alarm in the same cycle; load_alarm is dropped.
- Match: evaluated in the cycle after each tick_1hz. A slot matches if alarm_en[i]=1 and time == slot hh:mm:00. A load_time never produces a match. If several slots match, the lowest index wins.
- FSM states:
  IDLE: alarm=0. A match goes to RING with ring_cnt=0, rings=1, alarm_src=winner.
  RING: alarm=1. Each tick increments ring_cnt. Transitions:
    - stop_alarm -> IDLE.
    - snooze or (tick with ring_cnt==RING_SECS-1) -> SNOOZE if rings<MAX_RINGS, else IDLE. wait_cnt=0.
  SNOOZE: alarm=0. Each tick increments wait_cnt. Transitions:
    - stop_alarm -> IDLE.
    - tick with wait_cnt==SNOOZE_SECS-1 -> RING, rings+1, ring_cnt=0.
- snooze in IDLE or SNOOZE has no effect. If stop_alarm and snooze arrive together, stop wins.
- New matches while in RING or SNOOZE are ignored; alarm_src holds.
- alarm rises the cycle after the match cycle and falls the cycle after stop, snooze or timeout.
- Counter widths are sized by $clog2 of their parameter. No counter wraps within a state.

Test Plan:
Params CLK_HZ=4, RING_SECS=3, SNOOZE_SECS=2, MAX_RINGS=2 for all scenarios.
1. Reset with inputs 23:59 -> outputs 23:59:00. After 60 ticks -> 00:00:00. tick_1hz period is 4 clk.
2. load_time 14:07, then load_time 24:00 -> time stays 14:07:xx; the invalid load is ignored. load_time and load_alarm asserted together -> no slot changes.
3. Slots 1 and 2 = 14:08, both enabled, time at 14:07:59 -> alarm rises the cycle after the match; alarm_src=1.
4. No input after a match -> alarm high for 3 ticks, low for 2, high for 3, then IDLE with alarm=0.
5. snooze during the first ring -> low for 2 ticks, then high. stop_alarm during SNOOZE -> IDLE; no further ring.
6. rst_bar low for one clk during RING -> next cycle alarm=0, slots 00:00, time = inputs:00.
